// File: rtl/kpn_delay_scheduler.sv
// -----------------------------------------------------------------------------
// kpn_delay_scheduler
//
// Firing controller for a KPN delay actor that sits between an input FIFO and
// an output FIFO carrying 16-bit fixed-point tokens.
//
// After reset the controller first primes the output channel with
// DELAY_NUMBER copies of INIT_TOKEN. It then forwards tokens one at a time:
// read one token from the input FIFO, wait out the FIFO read latency, capture
// the data, and write it to the output FIFO. Every firing is gated by the
// FIFO empty/full flags.
//
// Parameters
//   DELAY_NUMBER  number of initial tokens written before the first forward
//                 (0 = no priming, legal range 0..255)
//   INIT_TOKEN    value of each initial token
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   enable_i       in   1   level, 1 = scheduler may fire
//   in_empty_i     in   1   input FIFO empty flag
//   in_data_i      in   16  input FIFO read data, valid 1 cycle after in_rd_o
//   in_rd_o        out  1   input FIFO read strobe, one pulse per token
//   out_full_i     in   1   output FIFO full flag
//   out_data_o     out  16  token to output FIFO, stable while out_wr_o=1
//   out_wr_o       out  1   output FIFO write strobe, one pulse per token
//   primed_o       out  1   1 once all initial tokens have been written
//   busy_o         out  1   1 in every state except IDLE
//   fire_count_o   out  16  forwarded tokens (priming excluded), wraps
//   stall_count_o  out  16  only with KPN_SCHED_STALL_CNT_EN defined: cycles
//                           spent blocked by out_full_i in PRIME or WRITE,
//                           saturating at 16'hFFFF
//
// Build option
//   KPN_SCHED_STALL_CNT_EN  adds the stall counter and its output port.
//
// All outputs are driven straight from flops; the strobes are computed from
// the flags sampled at one edge and appear during the following cycle.
// -----------------------------------------------------------------------------
module kpn_delay_scheduler #(
    parameter int unsigned DELAY_NUMBER = 4,
    parameter logic [15:0] INIT_TOKEN   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        in_empty_i,
    input  logic [15:0] in_data_i,
    output logic        in_rd_o,
    input  logic        out_full_i,
    output logic [15:0] out_data_o,
    output logic        out_wr_o,
    output logic        primed_o,
    output logic        busy_o,
    output logic [15:0] fire_count_o
`ifdef KPN_SCHED_STALL_CNT_EN
    ,
    output logic [15:0] stall_count_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_READ    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_WRITE   = 3'd5
    } state_e;

    // With no priming requested the scheduler comes out of reset already
    // primed, so IDLE goes straight to WAIT_IN.
    localparam logic       PRIME_NONE = (DELAY_NUMBER == 0);
    // Counter value at which the last initial token is being written.
    localparam logic [7:0] PRIME_LAST = (DELAY_NUMBER == 0) ? 8'd0
                                                            : 8'(DELAY_NUMBER - 1);

    state_e      state_q,      state_d;
    logic        in_rd_q,      in_rd_d;
    logic        out_wr_q,     out_wr_d;
    logic [15:0] out_data_q,   out_data_d;
    logic        primed_q,     primed_d;
    logic        busy_q,       busy_d;
    logic [15:0] fire_count_q, fire_count_d;
    logic [7:0]  prime_cnt_q,  prime_cnt_d;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        in_rd_d      = 1'b0;
        out_wr_d     = 1'b0;
        out_data_d   = out_data_q;
        primed_d     = primed_q;
        fire_count_d = fire_count_q;
        prime_cnt_d  = prime_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = primed_q ? ST_WAIT_IN : ST_PRIME;
                end
            end

            ST_PRIME: begin
                // Dropping enable pauses priming in place; the counter keeps
                // its value so priming resumes where it left off.
                if (enable_i && !out_full_i) begin
                    out_wr_d    = 1'b1;
                    out_data_d  = INIT_TOKEN;
                    prime_cnt_d = prime_cnt_q + 8'd1;
                    if (prime_cnt_q == PRIME_LAST) begin
                        // primed rises in the same cycle as the last write
                        primed_d = 1'b1;
                        state_d  = ST_WAIT_IN;
                    end
                end
            end

            ST_WAIT_IN: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (!in_empty_i) begin
                    in_rd_d = 1'b1;
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                // in_rd is high during this cycle; the FIFO presents the
                // data in the next one.
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                out_data_d = in_data_i;
                state_d    = ST_WRITE;
            end

            ST_WRITE: begin
                // A token already read is always delivered, so enable is
                // deliberately ignored here.
                if (!out_full_i) begin
                    out_wr_d     = 1'b1;
                    fire_count_d = fire_count_q + 16'd1;
                    state_d      = ST_WAIT_IN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_rd_q      <= 1'b0;
            out_wr_q     <= 1'b0;
            out_data_q   <= 16'h0000;
            primed_q     <= PRIME_NONE;
            busy_q       <= 1'b0;
            fire_count_q <= 16'h0000;
            prime_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            in_rd_q      <= in_rd_d;
            out_wr_q     <= out_wr_d;
            out_data_q   <= out_data_d;
            primed_q     <= primed_d;
            busy_q       <= busy_d;
            fire_count_q <= fire_count_d;
            prime_cnt_q  <= prime_cnt_d;
        end
    end

    assign in_rd_o      = in_rd_q;
    assign out_wr_o     = out_wr_q;
    assign out_data_o   = out_data_q;
    assign primed_o     = primed_q;
    assign busy_o       = busy_q;
    assign fire_count_o = fire_count_q;

`ifdef KPN_SCHED_STALL_CNT_EN
    // -------------------------------------------------------------------------
    // Back-pressure stall counter: one count per cycle spent in a writing
    // state with the output FIFO full. Saturates rather than wrapping.
    // -------------------------------------------------------------------------
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_PRIME || state_q == ST_WRITE) && out_full_i
            && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
`endif

endmodule
